// File: rtl/io_responder_pkg.sv
// Shared constants and types for the memory-mapped I/O responder.
package io_responder_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DEC_W  = 18;

  localparam logic [DEC_W-1:0] IO_UART = 18'h30000;
  localparam logic [DEC_W-1:0] IO_CLK  = 18'h30004;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_END   = 2'd2
  } state_e;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with (AW+1)-bit pointers; the extra MSB separates full from empty.
module io_fifo #(
  parameter int unsigned AW = 4,
  parameter int unsigned W  = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; pointers alone define the contents.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/io_responder.sv
// CPU byte-bus responder for the I/O window: UART RX/TX buffering, cycle counter, stop sequence.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int unsigned RX_AW = 4,
  parameter int unsigned TX_AW = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              bus_en,
  input  logic              bus_wr,
  input  logic [31:0]       bus_addr,
  input  logic [BYTE_W-1:0] bus_wdata,
  output logic [BYTE_W-1:0] bus_rdata,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              tx_overflow,
  output logic              prog_end
);

  state_e            state_q, state_d;
  logic              term_pend_q, term_pend_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  snap_q;
  logic              is_uart, is_clk;
  logic              rd_uart, rd_clk, wr_uart, wr_clk;
  logic              rx_full, rx_empty, rx_pop;
  logic [BYTE_W-1:0] rx_head;
  logic              tx_full, tx_empty, tx_push, tx_pop;
  logic [BYTE_W-1:0] tx_push_data;
  logic              ovf_set;
  logic [BYTE_W-1:0] rdata_d;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus_addr[31:DEC_W];

  assign is_uart = (bus_addr[DEC_W-1:0] == IO_UART);
  assign is_clk  = (bus_addr[DEC_W-1:2] == IO_CLK[DEC_W-1:2]);
  assign rd_uart = bus_en & ~bus_wr & is_uart;
  assign rd_clk  = bus_en & ~bus_wr & is_clk;
  assign wr_uart = bus_en & bus_wr & is_uart;
  assign wr_clk  = bus_en & bus_wr & (bus_addr[DEC_W-1:0] == IO_CLK);

  assign rx_pop   = rd_uart & ~rx_empty;
  assign tx_pop   = tx_ready & ~tx_empty;
  assign rx_ready = ~rx_full;
  assign tx_valid = ~tx_empty;

  io_fifo #(.AW(RX_AW), .W(BYTE_W)) u_rx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );

  io_fifo #(.AW(TX_AW), .W(BYTE_W)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_data)
  );

  // Stop sequence and TX write filtering; the terminator waits for a free slot if TX is full.
  always_comb begin
    state_d      = state_q;
    term_pend_d  = term_pend_q;
    tx_push      = 1'b0;
    tx_push_data = bus_wdata;
    ovf_set      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (wr_clk) begin
          state_d      = ST_DRAIN;
          tx_push_data = '0;
          if (tx_full) term_pend_d = 1'b1;
          else         tx_push     = 1'b1;
        end else if (wr_uart && (bus_wdata != '0)) begin
          if (tx_full) ovf_set = 1'b1;
          else         tx_push = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (term_pend_q) begin
          if (!tx_full) begin
            tx_push      = 1'b1;
            tx_push_data = '0;
            term_pend_d  = 1'b0;
          end
        end else if (tx_empty) begin
          state_d = ST_END;
        end
      end
      ST_END:  ;
      default: state_d = ST_RUN;
    endcase
  end

  // Read mux: counter byte 0 comes live because the snapshot loads on the same access.
  always_comb begin
    rdata_d = '0;
    if (is_uart) begin
      rdata_d = rx_empty ? '0 : rx_head;
    end else if (is_clk) begin
      case (bus_addr[1:0])
        2'd0:    rdata_d = cnt_q[7:0];
        2'd1:    rdata_d = snap_q[15:8];
        2'd2:    rdata_d = snap_q[23:16];
        default: rdata_d = snap_q[31:24];
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_RUN;
      term_pend_q <= 1'b0;
      cnt_q       <= '0;
      snap_q      <= '0;
      bus_rdata   <= '0;
      tx_overflow <= 1'b0;
      prog_end    <= 1'b0;
    end else begin
      state_q     <= state_d;
      term_pend_q <= term_pend_d;
      cnt_q       <= cnt_q + CNT_W'(1);
      prog_end    <= (state_d == ST_END);
      if (ovf_set) tx_overflow <= 1'b1;
      if (rd_clk && (bus_addr[1:0] == 2'b00)) snap_q <= cnt_q;
      if (bus_en && !bus_wr) bus_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder.
module tb_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        bus_en;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_overflow;
  logic        prog_end;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] txq [$];

  io_responder #(.RX_AW(4), .TX_AW(4)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .bus_en      (bus_en),
    .bus_wr      (bus_wr),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_overflow (tx_overflow),
    .prog_end    (prog_end)
  );

  always #5 clk_in = ~clk_in;

  // TX handshakes are stable between #1-after-edge and the next edge.
  always @(negedge clk_in) begin
    if (!rst_in && tx_valid && tx_ready) txq.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    bus_en = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_en = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
    bus_en = 1'b1; bus_wr = 1'b0; bus_addr = a;
    tick();
    bus_en = 1'b0;
    d = bus_rdata;
  endtask

  initial begin
    logic [7:0] rd;
    logic       all55;
    int         empty_cyc;
    int         end_cyc;

    rst_in = 1'b1; bus_en = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    do_reset();

    check("rst_rdata",    32'(bus_rdata),   32'h0);
    check("rst_tx_valid", 32'(tx_valid),    32'h0);
    check("rst_rx_ready", 32'(rx_ready),    32'h1);
    check("rst_overflow", 32'(tx_overflow), 32'h0);
    check("rst_prog_end", 32'(prog_end),    32'h0);

    // Counter snapshot at 0x12C, then coherence while the counter runs on.
    repeat (300) tick();
    bus_read(32'h30004, rd); check("cnt_b0", 32'(rd), 32'h2C);
    bus_read(32'h30005, rd); check("cnt_b1", 32'(rd), 32'h01);
    bus_read(32'h30006, rd); check("cnt_b2", 32'(rd), 32'h00);
    bus_read(32'h30007, rd); check("cnt_b3", 32'(rd), 32'h00);
    repeat (256) tick();
    bus_read(32'h30005, rd); check("snap_held", 32'(rd), 32'h01);
    bus_read(32'h30004, rd); check("cnt_reload_b0", 32'(rd), 32'h31);
    bus_read(32'h30005, rd); check("cnt_reload_b1", 32'(rd), 32'h02);
    bus_read(32'h30008, rd); check("other_addr_rd", 32'(rd), 32'h00);

    // RX path.
    rx_valid = 1'b1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_valid = 1'b0;
    bus_read(32'h30000, rd); check("rx_first",  32'(rd), 32'h41);
    bus_read(32'h30000, rd); check("rx_second", 32'(rd), 32'h42);
    bus_read(32'h30000, rd); check("rx_empty",  32'(rd), 32'h00);

    // RX full: a pop on a full FIFO does not admit a same-cycle push.
    for (int i = 0; i < 16; i++) begin
      rx_valid = 1'b1; rx_data = 8'(8'h10 + i); tick();
    end
    rx_valid = 1'b0;
    check("rx_full_ready", 32'(rx_ready), 32'h0);
    rx_valid = 1'b1; rx_data = 8'hEE;
    bus_read(32'h30000, rd);
    rx_valid = 1'b0;
    check("rx_full_pop", 32'(rd), 32'h10);
    check("rx_ready_after_pop", 32'(rx_ready), 32'h1);
    for (int i = 1; i < 16; i++) begin
      bus_read(32'h30000, rd);
      check("rx_drain", 32'(rd), 32'(8'h10 + i));
    end
    bus_read(32'h30000, rd); check("rx_no_ee", 32'(rd), 32'h00);

    // TX with zero filter; writes to an unmapped address are ignored.
    txq.delete();
    tx_ready = 1'b1;
    bus_write(32'h30000, 8'h48);
    bus_write(32'h30000, 8'h00);
    bus_write(32'h30000, 8'h69);
    bus_write(32'h30010, 8'h99);
    repeat (5) tick();
    check("tx_count", 32'(txq.size()), 32'd2);
    check("tx_b0", 32'(txq[0]), 32'h48);
    check("tx_b1", 32'(txq[1]), 32'h69);

    // TX overflow.
    do_reset();
    txq.delete();
    tx_ready = 1'b0;
    repeat (16) bus_write(32'h30000, 8'h55);
    check("ovf_before", 32'(tx_overflow), 32'h0);
    bus_write(32'h30000, 8'h55);
    check("ovf_after", 32'(tx_overflow), 32'h1);
    tx_ready = 1'b1;
    repeat (20) tick();
    all55 = 1'b1;
    foreach (txq[i]) if (txq[i] != 8'h55) all55 = 1'b0;
    check("ovf_count", 32'(txq.size()), 32'd16);
    check("ovf_data", 32'(all55), 32'h1);
    check("ovf_sticky", 32'(tx_overflow), 32'h1);
    check("ovf_drained", 32'(tx_valid), 32'h0);

    // Stop sequence with three queued bytes.
    do_reset();
    txq.delete();
    tx_ready = 1'b0;
    bus_write(32'h30000, 8'h31);
    bus_write(32'h30000, 8'h32);
    bus_write(32'h30000, 8'h33);
    bus_write(32'h30004, 8'h00);
    bus_write(32'h30000, 8'h77);
    check("drain_no_end", 32'(prog_end), 32'h0);
    tx_ready = 1'b1;
    empty_cyc = -1; end_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!tx_valid && empty_cyc < 0) empty_cyc = i;
      if (prog_end && end_cyc < 0) end_cyc = i;
    end
    check("stop_seen", 32'(end_cyc >= 0 && empty_cyc >= 0), 32'h1);
    check("stop_timing", 32'(end_cyc - empty_cyc), 32'd1);
    check("stop_count", 32'(txq.size()), 32'd4);
    check("stop_b0", 32'(txq[0]), 32'h31);
    check("stop_b1", 32'(txq[1]), 32'h32);
    check("stop_b2", 32'(txq[2]), 32'h33);
    check("stop_term", 32'(txq[3]), 32'h00);
    bus_write(32'h30000, 8'h78);
    bus_write(32'h30004, 8'h00);
    repeat (5) tick();
    check("end_no_tx", 32'(txq.size()), 32'd4);
    check("end_sticky", 32'(prog_end), 32'h1);
    rx_valid = 1'b1; rx_data = 8'h5A; tick(); rx_valid = 1'b0;
    bus_read(32'h30000, rd); check("end_rx_read", 32'(rd), 32'h5A);

    // Stop with TX full: the terminator waits for a free slot.
    do_reset();
    txq.delete();
    tx_ready = 1'b0;
    repeat (16) bus_write(32'h30000, 8'hA5);
    bus_write(32'h30004, 8'h00);
    check("full_term_no_ovf", 32'(tx_overflow), 32'h0);
    tx_ready = 1'b1;
    end_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (prog_end && end_cyc < 0) end_cyc = i;
    end
    check("full_term_end", 32'(end_cyc >= 0), 32'h1);
    check("full_term_count", 32'(txq.size()), 32'd17);
    check("full_term_last", 32'(txq[16]), 32'h00);

    // Reset in the middle of a drain.
    do_reset();
    tx_ready = 1'b0;
    bus_write(32'h30000, 8'h61);
    bus_write(32'h30000, 8'h62);
    bus_write(32'h30004, 8'h00);
    rst_in = 1'b1;
    tick();
    check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("mid_rst_prog_end", 32'(prog_end), 32'h0);
    check("mid_rst_rx_ready", 32'(rx_ready), 32'h1);
    rst_in = 1'b0;
    bus_read(32'h30004, rd); check("mid_rst_cnt0", 32'(rd), 32'h00);
    txq.delete();
    tx_ready = 1'b1;
    bus_write(32'h30000, 8'h41);
    repeat (3) tick();
    check("mid_rst_run_cnt", 32'(txq.size()), 32'd1);
    check("mid_rst_run_b0", 32'(txq[0]), 32'h41);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
